bus_trace_fifo: RTL

- Parametrised successor to the simulation-only bus tracer.
- Synthesisable capture of CPU bus strobe completions (mem/io read/write) into an on-chip FIFO. Each entry holds channel id, free-running timestamp, latched address and data.
- Sits beside the CPU arbiter in the system block. Entries drain through a first-word-fall-through pop port to a debug UART or an IO-mapped reader.
- Supports stop-on-full and wrap (overwrite-oldest) modes, a per-channel enable mask and lost-event accounting.

---
 rtl/bus_trace_pkg.sv | 31 +++
 rtl/bus_trace_fifo_core.sv | 73 +++++++
 rtl/bus_trace_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/bus_trace_pkg.sv
// Shared definitions for the bus trace FIFO: channel indices, default read-channel
// mask and the packed entry layout {chan, ts, addr, data} from MSB down.
package bus_trace_pkg;

    localparam int CH_IOR  = 0;
    localparam int CH_IOW  = 1;
    localparam int CH_MEMR = 2;
    localparam int CH_MEMW = 3;

    // IOR and MemR capture the data driven towards the CPU.
    localparam logic [3:0] CH_IS_READ_DEFAULT = 4'b0101;

    localparam int DATA_LSB = 0;

    function automatic int addrLsb(input int dataW);
        return DATA_LSB + dataW;
    endfunction

    function automatic int tsLsb(input int dataW, input int addrW);
        return addrLsb(dataW) + addrW;
    endfunction

    function automatic int chanLsb(input int dataW, input int addrW, input int tsW);
        return tsLsb(dataW, addrW) + tsW;
    endfunction

    function automatic int entryWidth(input int chW, input int tsW, input int addrW, input int dataW);
        return chanLsb(dataW, addrW, tsW) + chW;
    endfunction

endpackage

// File: rtl/bus_trace_fifo_core.sv
// First-word-fall-through FIFO with optional overwrite-oldest behaviour when full.
// Reports per-cycle drop/overwrite pulses so the caller can account for lost events.
module trace_fifo_core #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 64,
    parameter int WRAP_MODE = 0,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iClear,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iPushData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oData,
    output logic             oValid,
    output logic [CNT_W-1:0] oCount,
    output logic             oFull,
    output logic             oDropped,
    output logic             oOverwrite
);

    localparam bit WRAP = (WRAP_MODE != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [CNT_W-1:0] countReg, countNext;
    logic             popOk, pushReq, writeEn, advRd, full;

    always_comb begin
        full       = (countReg == CNT_W'(DEPTH));
        popOk      = iPop && (countReg != '0) && !iClear;
        pushReq    = iPush && !iClear;
        writeEn    = pushReq && (!full || popOk || WRAP);
        oOverwrite = pushReq && full && !popOk && WRAP;
        oDropped   = pushReq && full && !popOk && !WRAP;
        advRd      = popOk || oOverwrite;
        countNext  = countReg;
        // An overwrite replaces the oldest entry, so occupancy is unchanged.
        if ((writeEn && !oOverwrite) && !popOk) begin
            countNext = countReg + CNT_W'(1);
        end else if (!(writeEn && !oOverwrite) && popOk) begin
            countNext = countReg - CNT_W'(1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            countReg <= '0;
        end else if (iClear) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            countReg <= '0;
        end else begin
            if (writeEn) wrPtr <= wrPtr + PTR_W'(1);
            if (advRd)   rdPtr <= rdPtr + PTR_W'(1);
            countReg <= countNext;
        end
    end

    always_ff @(posedge iClk) begin
        if (writeEn) mem[wrPtr] <= iPushData;
    end

    assign oData  = mem[rdPtr];
    assign oValid = (countReg != '0);
    assign oCount = countReg;
    assign oFull  = full;

endmodule

// File: rtl/bus_trace_fifo.sv
// Captures CPU bus strobe completions (falling edges) into a trace FIFO with
// timestamp, address and data; arbitrates simultaneous events and counts losses.
module bus_trace_fifo
    import bus_trace_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter logic [CHANNELS-1:0] CH_IS_READ = CHANNELS'(CH_IS_READ_DEFAULT),
    parameter int DEPTH     = 64,
    parameter int TS_W      = 16,
    parameter int WRAP_MODE = 0,
    parameter int CH_W      = $clog2(CHANNELS),
    parameter int ENTRY_W   = entryWidth(CH_W, TS_W, ADDR_W, DATA_W)
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iEnable,
    input  logic [CHANNELS-1:0]      iChanMask,
    input  logic                     iClear,
    input  logic [ADDR_W-1:0]        iAddr,
    input  logic [DATA_W-1:0]        iDataR,
    input  logic [DATA_W-1:0]        iDataW,
    input  logic [CHANNELS-1:0]      iStrobe,
    input  logic                     iPop,
    output logic                     oValid,
    output logic [ENTRY_W-1:0]       oEntry,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oFull,
    output logic                     oOverflow,
    output logic [7:0]               oLost
);

    localparam int QC_W = $clog2(CHANNELS + 1);

    logic [CHANNELS-1:0] sOld, evQual;
    logic [TS_W-1:0]     tsReg;
    logic [7:0]          lostReg, lostNext;
    logic                overflowReg;
    logic [CH_W-1:0]     selChan;
    logic [QC_W-1:0]     qualCnt, lostInc;
    logic [9:0]          lostSum;
    logic [DATA_W-1:0]   selData;
    logic                coreDropped, coreOverwrite;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : gEdge
        assign evQual[gi] = iEnable & iChanMask[gi] & sOld[gi] & ~iStrobe[gi];
    end

    // Scan high to low so the lowest qualified channel wins.
    always_comb begin
        selChan = CH_W'(CH_IOR);
        qualCnt = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (evQual[c]) begin
                selChan = CH_W'(c);
                qualCnt = qualCnt + QC_W'(1);
            end
        end
    end

    always_comb begin
        selData = CH_IS_READ[selChan] ? iDataR : iDataW;
        lostInc = ((qualCnt != '0) ? (qualCnt - QC_W'(1)) : '0)
                + QC_W'(coreDropped | coreOverwrite);
        lostSum  = {2'b00, lostReg} + 10'(lostInc);
        lostNext = (lostSum > 10'd255) ? 8'hFF : lostSum[7:0];
    end

    trace_fifo_core #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (DEPTH),
        .WRAP_MODE (WRAP_MODE)
    ) uCore (
        .iClk       (iClk),
        .iRst       (iRst),
        .iClear     (iClear),
        .iPush      (|evQual),
        .iPushData  ({selChan, tsReg, iAddr, selData}),
        .iPop       (iPop),
        .oData      (oEntry),
        .oValid     (oValid),
        .oCount     (oCount),
        .oFull      (oFull),
        .oDropped   (coreDropped),
        .oOverwrite (coreOverwrite)
    );

    // Strobe history keeps tracking through iClear so no false edges appear.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sOld        <= '0;
            tsReg       <= '0;
            lostReg     <= '0;
            overflowReg <= 1'b0;
        end else begin
            sOld <= iStrobe;
            if (iClear) begin
                tsReg       <= '0;
                lostReg     <= '0;
                overflowReg <= 1'b0;
            end else begin
                tsReg   <= tsReg + TS_W'(1);
                lostReg <= lostNext;
                if (lostInc != '0) overflowReg <= 1'b1;
            end
        end
    end

    assign oLost     = lostReg;
    assign oOverflow = overflowReg;

endmodule
